// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM states and grant encoding for the memory arbiter
package mem_arb_pkg;
   localparam int ADDR_W = 28;
   localparam int LINE_W = 128;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
   typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: winner selection between I-cache and D-cache requests (round-robin when ARB_RR_EN is defined, else D-cache priority)
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic ireq_i,
   input  logic dreq_i,
`ifdef ARB_RR_EN
   input  gnt_t ptr_i,
`endif
   output gnt_t gnt_o
);
`ifdef ARB_RR_EN
   // the pointer names the side preferred on a tie
   assign gnt_o = (dreq_i && (!ireq_i || ptr_i == GNT_D)) ? GNT_D : GNT_I;
`else
   // D-cache always wins a tie
   assign gnt_o = (dreq_i || !ireq_i) ? GNT_D : GNT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit memory port between I-cache and D-cache; ARB_RR_EN selects round-robin arbitration
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              icache_mem_read,
   input  logic [ADDR_W-1:0] icache_mem_addr,
   output logic [LINE_W-1:0] icache_mem_rdata,
   output logic              icache_mem_ready,
   input  logic              dcache_mem_read,
   input  logic              dcache_mem_write,
   input  logic [ADDR_W-1:0] dcache_mem_addr,
   input  logic [LINE_W-1:0] dcache_mem_wdata,
   output logic [LINE_W-1:0] dcache_mem_rdata,
   output logic              dcache_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   state_t state_q, state_d;
   gnt_t gnt_q, gnt_d, pick;
   logic rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic d_req, i_sel, d_sel;
`ifdef ARB_RR_EN
   gnt_t ptr_q, ptr_d;
`endif
   assign d_req = dcache_mem_read | dcache_mem_write;
   arb_pick u_pick (
      .ireq_i(icache_mem_read),
      .dreq_i(d_req),
`ifdef ARB_RR_EN
      .ptr_i (ptr_q),
`endif
      .gnt_o (pick)
   );
   // next state: latch the winner in IDLE, hold until mem_ready, then one dead cycle
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: if (icache_mem_read || d_req) begin
            state_d = BUSY;
            gnt_d   = pick;
            wr_d    = pick == GNT_D && dcache_mem_write;
            rd_d    = !wr_d;
            addr_d  = pick == GNT_D ? dcache_mem_addr : icache_mem_addr;
            wdata_d = pick == GNT_D ? dcache_mem_wdata : '0;
`ifdef ARB_RR_EN
            ptr_d   = pick == GNT_D ? GNT_I : GNT_D;
`endif
         end
         BUSY: if (mem_ready) begin
            state_d = RELEASE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered memory-side outputs
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= IDLE;
         gnt_q   <= GNT_I;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_RR_EN
         ptr_q   <= GNT_D;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end
   assign i_sel            = !proc_reset && state_q == BUSY && gnt_q == GNT_I;
   assign d_sel            = !proc_reset && state_q == BUSY && gnt_q == GNT_D;
   assign icache_mem_ready = i_sel & mem_ready;
   assign dcache_mem_ready = d_sel & mem_ready;
   assign icache_mem_rdata = i_sel ? mem_rdata : '0;
   assign dcache_mem_rdata = d_sel ? mem_rdata : '0;
   assign mem_read         = rd_q;
   assign mem_write        = wr_q;
   assign mem_addr         = addr_q;
   assign mem_wdata        = wdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: proc_reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: icache_mem_read  input  1; icache_mem_addr  input  28  I-cache line address.
REQ-004 SHALL have ports: icache_mem_rdata  output  128; icache_mem_ready  output  1  I-cache completion.
REQ-005 SHALL have ports: dcache_mem_read, dcache_mem_write  input  1 each; dcache_mem_addr  input  28; dcache_mem_wdata  input  128.
REQ-006 SHALL have ports: dcache_mem_rdata  output  128; dcache_mem_ready  output  1  D-cache completion.
REQ-007 SHALL have ports: mem_read, mem_write  output  1 each; mem_addr  output  28; mem_wdata  output  128.
REQ-008 SHALL have ports: mem_rdata  input  128; mem_ready  input  1  shared memory completion.

Function
REQ-009 SHALL share one 128-bit memory port between I-cache and D-cache; requests are levels held by the requester until its ready pulse.
REQ-010 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-011 IDLE: any request pending -> pick winner, latch grant/op/addr/wdata, go BUSY; none -> stay IDLE.
REQ-012 mem_read/mem_write/mem_addr/mem_wdata SHALL be registered; asserted the cycle after the winning request is sampled in IDLE (1-cycle latency).
REQ-013 BUSY: hold mem_* constant until mem_ready=1; then clear mem_read/mem_write at that edge, go RELEASE.
REQ-014 mem_ready and mem_rdata SHALL be forwarded combinationally only to the granted requester while in BUSY; the other side sees ready=0, rdata=0.
REQ-015 RELEASE: one dead cycle, no arbitration, no ready forwarded; then IDLE (prevents re-granting a stale request).
REQ-016 mem_ready in IDLE or RELEASE SHALL be ignored.
REQ-017 Requester inputs SHALL be ignored while BUSY (latched copy used); input changes mid-transaction do not alter mem_*.
REQ-018 dcache_mem_read and dcache_mem_write both high: treated as write.
REQ-019 Back-to-back: minimum 3 cycles per transaction plus memory latency; a D-cache write-back followed by allocate read SHALL be served as two separate grants.

Reset
REQ-020 proc_reset=1 at an edge SHALL force IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, grant cleared, priority pointer to D-cache.
REQ-021 Reset during BUSY SHALL abandon the transaction; no ready pulse is emitted to either requester.

Configuration
REQ-022 Macro ARB_RR_EN defined: round-robin; on simultaneous requests the side not granted last wins; pointer updated on each grant.
REQ-023 ARB_RR_EN undefined: fixed priority, D-cache always wins over I-cache; no pointer register.

Structure
REQ-024 Package mem_arb_pkg SHALL hold state enum, ADDR_W=28, LINE_W=128, grant encoding (GNT_I, GNT_D).
REQ-025 Winner selection SHALL be one sub-module arb_pick (two requests + pointer -> grant); FSM and datapath stay in mem_arbiter.

Verification
REQ-026 I read only, addr 28'h0000010, memory ready after 4 cycles with rdata 128'hA5..A5 -> mem_read high cycles 1-4, icache_mem_ready=1 in cycle 4 with data; dcache_mem_ready=0 throughout.
REQ-027 I and D read same cycle, ARB_RR_EN undefined -> D granted first, I granted after RELEASE; repeat -> D wins again.
REQ-028 Same with ARB_RR_EN defined, repeated 4 times -> grants alternate D, I, D, I.
REQ-029 D write addr 28'h0000020 wdata 128'h1234 then read same addr -> mem_write grant, RELEASE, mem_read grant; no overlap of mem_read and mem_write.
REQ-030 proc_reset asserted 2 cycles into BUSY -> next cycle mem_read=0, state IDLE, no ready to either side; spurious mem_ready ignored.
REQ-031 mem_ready pulsed while IDLE with no requests -> no output change, no ready forwarded.
